// File: rtl/text_console_ctrl.sv
// Text console write scheduler for text VRAM port A.
// Keeps a cursor and expands commands into VRAM cell writes.
module text_console_ctrl #(
  parameter int          COLS        = 50,
  parameter int          ROWS        = 15,
  parameter int          WAIT_VBLANK = 1,
  parameter logic [7:0]  DEF_ATTR    = 8'h07
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic        vblank,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [5:0]  cur_col,
  output logic [3:0]  cur_row,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    FILL
  } state_t;

  localparam logic [2:0] OP_PUTC    = 3'd1;
  localparam logic [2:0] OP_NEWLINE = 3'd2;
  localparam logic [2:0] OP_CLEAR   = 3'd3;
  localparam logic [2:0] OP_SETPOS  = 3'd4;
  localparam logic [2:0] OP_SETATTR = 3'd5;

  localparam logic [5:0]  COL_MAX   = 6'(COLS - 1);
  localparam logic [3:0]  ROW_MAX   = 4'(ROWS - 1);
  localparam logic [11:0] COLS12    = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [7:0]  SPACE     = 8'h20;

  state_t      state;
  logic [7:0]  attr;
  logic [11:0] fill_addr;
  logic [11:0] fill_end;
  logic        fill_done;

  logic [11:0] cur_addr;
  logic [3:0]  next_row;
  logic [11:0] next_base;
  logic [5:0]  arg_col;
  logic [3:0]  arg_row;
  logic        go_fill;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Cursor address, wrapped next row and clamped SETPOS operands.
  always_comb begin
    cur_addr  = {8'd0, cur_row} * COLS12 + {6'd0, cur_col};
    next_row  = (cur_row == ROW_MAX) ? 4'd0 : cur_row + 4'd1;
    next_base = {8'd0, next_row} * COLS12;
    arg_col   = (cmd_arg[5:0] > COL_MAX) ? COL_MAX : cmd_arg[5:0];
    arg_row   = (cmd_arg[11:8] > ROW_MAX) ? ROW_MAX : cmd_arg[11:8];
    go_fill   = (WAIT_VBLANK == 0) || vblank;
  end

  // Command FSM, cursor, fill counter and registered VRAM port.
  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      attr      <= DEF_ATTR;
      cur_col   <= '0;
      cur_row   <= '0;
      fill_addr <= '0;
      fill_end  <= '0;
      fill_done <= 1'b0;
      ram_ce    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      ram_ce <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUTC: begin
                ram_ce   <= 1'b1;
                ram_addr <= cur_addr;
                ram_data <= cmd_arg;
                if (cur_col == COL_MAX) begin
                  cur_col   <= '0;
                  cur_row   <= next_row;
                  fill_addr <= next_base;
                  fill_end  <= next_base + COLS12 - 12'd1;
                  fill_done <= 1'b0;
                  state     <= FILL;
                end else begin
                  cur_col <= cur_col + 6'd1;
                end
              end
              OP_NEWLINE: begin
                cur_col   <= '0;
                cur_row   <= next_row;
                fill_addr <= next_base;
                fill_end  <= next_base + COLS12 - 12'd1;
                fill_done <= 1'b0;
                state     <= FILL;
              end
              OP_CLEAR: begin
                attr      <= cmd_arg[15:8];
                cur_col   <= '0;
                cur_row   <= '0;
                fill_addr <= '0;
                fill_end  <= LAST_CELL;
                fill_done <= 1'b0;
                state     <= go_fill ? FILL : WAIT_VB;
              end
              OP_SETPOS: begin
                cur_col <= arg_col;
                cur_row <= arg_row;
              end
              OP_SETATTR: begin
                attr <= cmd_arg[15:8];
              end
              default: begin
              end
            endcase
          end
        end
        WAIT_VB: begin
          if (vblank) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (fill_done) begin
            fill_done <= 1'b0;
            state     <= IDLE;
          end else begin
            ram_ce   <= 1'b1;
            ram_addr <= fill_addr;
            ram_data <= {attr, SPACE};
            if (fill_addr == fill_end) begin
              fill_done <= 1'b1;
            end else begin
              fill_addr <= fill_addr + 12'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl.
// Expected VRAM writes come from a cursor/page model.
module tb_text_console_ctrl;

  localparam int COLS = 50;
  localparam int ROWS = 15;

  logic        clk_pix;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        vblank;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic [5:0]  cur_col;
  logic [3:0]  cur_row;
  logic        busy;

  text_console_ctrl #(
    .COLS(COLS),
    .ROWS(ROWS),
    .WAIT_VBLANK(1),
    .DEF_ATTR(8'h07)
  ) dut (
    .clk_pix(clk_pix),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .vblank(vblank),
    .ram_ce(ram_ce),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .cur_col(cur_col),
    .cur_row(cur_row),
    .busy(busy)
  );

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
    logic        f;
  } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_col;
  int   m_row;
  logic [7:0] m_attr;
  logic rand_vb = 1'b0;

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push(input int a, input logic [15:0] d, input logic f);
    wr_t w;
    w.a = 12'(a);
    w.d = d;
    w.f = f;
    exp_q.push_back(w);
  endtask

  task automatic m_adv();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++)
      push(m_row * COLS + c, {m_attr, 8'h20}, 1'b1);
  endtask

  task automatic m_cmd(input logic [2:0] op, input logic [15:0] arg);
    logic wrap;
    int   v;
    case (op)
      3'd1: begin
        wrap = (m_col == COLS - 1);
        push(m_row * COLS + m_col, arg, wrap);
        if (wrap) begin
          m_col = 0;
          m_adv();
        end else begin
          m_col++;
        end
      end
      3'd2: begin
        m_col = 0;
        m_adv();
      end
      3'd3: begin
        m_attr = arg[15:8];
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < COLS * ROWS; i++)
          push(i, {m_attr, 8'h20}, 1'b1);
      end
      3'd4: begin
        v = int'(arg[5:0]);
        m_col = (v > COLS - 1) ? COLS - 1 : v;
        v = int'(arg[11:8]);
        m_row = (v > ROWS - 1) ? ROWS - 1 : v;
      end
      3'd5: m_attr = arg[15:8];
      default: begin
      end
    endcase
  endtask

  // Monitor: every VRAM strobe must match the next expected write.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk_pix);
      #1;
      if (reset && ram_ce) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected",
                   ram_addr, ram_data);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", ram_addr, w.a);
          chk("wr_data", ram_data, w.d);
          chk("wr_busy", busy, w.f);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic rvb();
    if (rand_vb) vblank = ($urandom % 4) == 0;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] arg);
    int n = 0;
    @(negedge clk_pix);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    rvb();
    while (!cmd_ready && n < 3000) begin
      @(negedge clk_pix);
      rvb();
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got cmd_ready 0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    m_cmd(op, arg);
    @(posedge clk_pix);
    #1;
    chk("cur_col", cur_col, m_col);
    chk("cur_row", cur_row, m_row);
    chk("ce_after_cmd", ram_ce, op == 3'd1);
  endtask

  task automatic idle();
    @(negedge clk_pix);
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_pix);
    while (!(cmd_ready && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk_pix);
      rvb();
      n++;
    end
    chk("idle_reached", cmd_ready && exp_q.size() == 0, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int n;
    int run;
    int ce_seen;
    int r;
    logic [2:0] op;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_arg = 16'h0;
    vblank = 1'b0;
    m_col = 0;
    m_row = 0;
    m_attr = 8'h07;
    repeat (3) @(negedge clk_pix);
    chk("rst_ce", ram_ce, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b1;
    @(negedge clk_pix);
    chk("rel_busy", busy, 0);
    chk("rel_col", cur_col, 0);
    chk("rel_row", cur_row, 0);

    send(3'd1, 16'h0741);
    send(3'd4, 16'h0E31);
    send(3'd1, 16'h0742);
    chk("wrap_busy", busy, 1);
    idle();
    wait_idle();

    send(3'd4, 16'h3F3F);
    idle();

    send(3'd3, 16'h1F00);
    idle();
    ce_seen = 0;
    repeat (100) begin
      @(negedge clk_pix);
      if (ram_ce) ce_seen++;
    end
    chk("clear_waits_vblank", ce_seen, 0);
    chk("clear_pending_busy", busy, 1);
    vblank = 1'b1;
    n = 0;
    while (!ram_ce && n < 50) begin
      @(negedge clk_pix);
      n++;
    end
    run = 0;
    while (ram_ce && run < 2000) begin
      run++;
      @(negedge clk_pix);
    end
    chk("clear_run_len", run, COLS * ROWS);
    vblank = 1'b0;
    wait_idle();

    send(3'd4, 16'h0305);
    for (int i = 0; i < 8; i++)
      send(3'd1, 16'(16'h0730 + i));
    idle();
    wait_idle();

    vblank = 1'b1;
    send(3'd3, 16'h2E00);
    idle();
    n = 0;
    while (!(ram_ce && ram_addr == 12'd300) && n < 2000) begin
      @(negedge clk_pix);
      n++;
    end
    chk("reached_300", ram_addr, 300);
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    m_attr = 8'h07;
    chk("abort_ce", ram_ce, 0);
    chk("abort_col", cur_col, 0);
    chk("abort_row", cur_row, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk_pix);
    reset = 1'b1;
    repeat (20) @(negedge clk_pix);
    chk("abort_ready", cmd_ready, 1);
    vblank = 1'b0;
    send(3'd2, 16'h0);
    idle();
    wait_idle();

    rand_vb = 1'b1;
    repeat (300) begin
      r = $urandom % 40;
      if (r < 20) op = 3'd1;
      else if (r < 24) op = 3'd2;
      else if (r < 25) op = 3'd3;
      else if (r < 29) op = 3'd4;
      else if (r < 32) op = 3'd5;
      else if (r < 35) op = 3'd0;
      else op = (r & 1) ? 3'd6 : 3'd7;
      send(op, 16'($urandom));
      if (($urandom % 4) == 0) idle();
    end
    idle();
    wait_idle();
    repeat (5) @(negedge clk_pix);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
